alu_issue_ctrl: RTL

- Execute-stage initiator for the 4-bit-opcode integer ALU.
- Accepts a decoded instruction request (ALUOp class, funct3, funct7[5], operands, tag) over valid/ready and translates it to the ALU Operation code.
- Drives SrcA/SrcB/Operation to the ALU from registers, captures ALUResult one cycle later, and returns result, branch-taken flag and illegal flag over a valid/ready response channel.

---
 rtl/alu_issue_pkg.sv | 39 +++
 rtl/alu_op_decode.sv | 64 ++++++
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_pkg                                                |
// | Description : Shared types for the ALU issue controller.                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package alu_issue_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_e;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SUB = 4'b0100,
    OP_SLT = 4'b0101,
    OP_SLL = 4'b0110,
    OP_SRL = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SRA = 4'b1001,
    OP_BNE = 4'b1010
  } alu_opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_op_decode                                                |
// | Description : Maps ALUOp class / funct3 / funct7[5] to the ALU Operation.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [3:0] op,
  output logic       illegal,
  output logic       invert_taken,
  output logic       is_branch
);

  always_comb begin
    op           = OP_ADD;
    illegal      = 1'b0;
    invert_taken = 1'b0;
    is_branch    = 1'b0;
    case (aluop)
      ALUOP_MEM: op = OP_ADD;
      ALUOP_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          3'b000:  op = OP_BEQ;
          3'b001:  op = OP_BNE;
          3'b100:  op = OP_SLT;
          // BGE reuses SLT and inverts the outcome
          3'b101: begin
            op           = OP_SLT;
            invert_taken = 1'b1;
          end
          default: begin
            op      = OP_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: begin
        case (funct3)
          3'b000:  op = (aluop == ALUOP_RTYPE && funct7b5) ? OP_SUB : OP_ADD;
          3'b111:  op = OP_AND;
          3'b110:  op = OP_OR;
          3'b100:  op = OP_XOR;
          3'b010:  op = OP_SLT;
          3'b001:  op = OP_SLL;
          3'b101:  op = funct7b5 ? OP_SRA : OP_SRL;
          default: begin
            op      = OP_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl                                               |
// | Description : Execute-stage initiator: decodes a request, drives the ALU   |
// |               from registers and returns the result over valid/ready.      |
// |               ALU_ISSUE_OVERLAP_EN lets a new request be accepted on the   |
// |               response handshake edge.                                     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_aluop,
  input  logic [2:0]               req_funct3,
  input  logic                     req_funct7b5,
  input  logic [DATA_WIDTH-1:0]    req_srca,
  input  logic [DATA_WIDTH-1:0]    req_srcb,
  input  logic [TAG_WIDTH-1:0]     req_tag,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_result,
  output logic                     resp_taken,
  output logic                     resp_illegal,
  output logic [TAG_WIDTH-1:0]     resp_tag
);

  state_e                 r_state;
  logic [TAG_WIDTH-1:0]   r_tag;
  logic                   r_illegal;
  logic                   r_invert;
  logic                   r_branch;

  logic [3:0]             w_op;
  logic                   w_illegal;
  logic                   w_invert;
  logic                   w_branch;
  logic                   w_accept;

  alu_op_decode u_decode (
    .aluop        (req_aluop),
    .funct3       (req_funct3),
    .funct7b5     (req_funct7b5),
    .op           (w_op),
    .illegal      (w_illegal),
    .invert_taken (w_invert),
    .is_branch    (w_branch)
  );

`ifdef ALU_ISSUE_OVERLAP_EN
  assign req_ready = rst_n && ((r_state == ST_IDLE) || (r_state == ST_RESP && resp_ready));
`else
  assign req_ready = rst_n && (r_state == ST_IDLE);
`endif

  assign w_accept = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_tag        <= '0;
      r_illegal    <= 1'b0;
      r_invert     <= 1'b0;
      r_branch     <= 1'b0;
      alu_srca     <= '0;
      alu_srcb     <= '0;
      alu_op       <= '0;
      resp_valid   <= 1'b0;
      resp_result  <= '0;
      resp_taken   <= 1'b0;
      resp_illegal <= 1'b0;
      resp_tag     <= '0;
    end else begin
      // alu_* hold from one accept to the next
      if (w_accept) begin
        alu_srca  <= req_srca;
        alu_srcb  <= req_srcb;
        alu_op    <= OPCODE_LENGTH'(w_op);
        r_tag     <= req_tag;
        r_illegal <= w_illegal;
        r_invert  <= w_invert;
        r_branch  <= w_branch;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          resp_result  <= alu_result;
          resp_taken   <= r_branch && !r_illegal && (alu_result[0] ^ r_invert);
          resp_illegal <= r_illegal;
          resp_tag     <= r_tag;
          resp_valid   <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            r_state    <= w_accept ? ST_ISSUE : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
